h_uart_rx: RTL
==============

# h_uart_rx

Serial receive end of the host-to-board load link for the Hack computer. The block samples an asynchronous 8N1 UART line, assembles consecutive bytes into 16-bit Hack words (high byte first) and presents each completed word with a one-cycle strobe. It sits between the board RX pin and the ROM/RAM loader, which writes `word_out` on each `word_valid` pulse.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be ≥ 4; even values are recommended.
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `rst`  in  1: asynchronous, active-high reset. It clears all state immediately.
- `rx`  in  1: raw serial line, asynchronous to `clk`. The line idles high.
- `word_out`  out  16: last completed word. The high byte is the first byte received.
- `word_valid`  out  1: one-cycle strobe that fires when `word_out` is updated.
- `frame_err`  out  1: one-cycle strobe that fires on a bad stop bit (or bad parity when parity is compiled in).
- `busy`  out  1: high while a byte frame is in progress (any state other than IDLE).

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rxs`.
- **Bit counter.** The cycle counter is `$clog2(CLKS_PER_BIT)` bits wide. The bit index is 3 bits.
- **State machine:** IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
  - **IDLE:** on `rxs`=0, go to START and clear the cycle counter.
  - **START:** wait `CLKS_PER_BIT/2` cycles, then sample.
    - If `rxs`=0, go to DATA with bit index 0.
    - If `rxs`=1, treat it as a glitch and return to IDLE with no strobe.
  - **DATA:** sample every `CLKS_PER_BIT` cycles (mid-bit). Bits arrive LSB first into the byte shift register. After bit 7, go to PARITY if compiled in, otherwise STOP.
  - **PARITY:** sample one bit after `CLKS_PER_BIT` cycles, then go to STOP.
  - **STOP:** sample after `CLKS_PER_BIT` cycles.
    - If `rxs`=1 and parity is OK, the byte is good. Return to IDLE.
    - Otherwise, pulse `frame_err`, discard the byte, clear the word phase (any pending high byte is dropped) and go to WAIT_IDLE.
  - **WAIT_IDLE:** stay until `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- **Word assembly.** A 1-bit phase register, reset to 0, tracks position in the word.
  - Good byte with phase 0: latch it as the high byte and set phase to 1.
  - Good byte with phase 1: load `word_out` = {high, byte}, pulse `word_valid` and set phase to 0.
- **Outputs.** `word_out` holds its value until the next completed word. It is never altered by errors.
- **Reset values.** `word_out`=16'h0000, `word_valid`=0, `frame_err`=0, `busy`=0. The state machine goes to IDLE, phase is 0 and the shift register is 0.
- **Reset mid-frame.** Reset takes effect immediately. A partial byte or a pending high byte is lost, and no strobe fires.
- **Strobe exclusivity.** `word_valid` and `frame_err` are never high in the same cycle.

## Timing
- **Synchronizer latency.** A falling edge on `rx` is visible on `rxs` 2 cycles later.
- **Sample points.** The start bit is sampled `CLKS_PER_BIT/2` cycles after detection. Each following bit is sampled `CLKS_PER_BIT` cycles after the previous sample.
- **Strobe timing.** `word_valid` or `frame_err` is registered on the same edge as the stop-bit sample and is high for exactly 1 cycle.
- **Total latency.** From the `rx` falling edge of the second byte's start bit to `word_valid` is 2 + `CLKS_PER_BIT`·9.5 cycles (10.5 with parity), ±1 cycle.
- **Back-to-back frames.** A start bit beginning immediately after the stop-bit sample is accepted. IDLE is re-entered on the same cycle as the strobe.
- **Throughput.** There is no backpressure. The consumer must take `word_out` within 2 byte times of `word_valid`.

## Configuration
- `H_UART_RX_PARITY_EN`: when defined, one even-parity bit follows the data bits.
  - A parity mismatch at the STOP sample is reported on `frame_err` and is handled exactly like a bad stop bit.
- When the macro is undefined, the frame is 8N1, the PARITY state and parity logic are absent, and frame timing is 10 bits.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Normal word:** after reset, send bytes 0x12 then 0x34 → exactly one `word_valid` pulse, `word_out`=16'h1234, `frame_err` never set.
- **Glitch rejection:** hold `rx` low for 4 cycles, then high → `busy` rises and falls, no strobes, state returns to IDLE.
- **Bad stop bit:** send byte 0x55 with stop bit 0, release the line, then send 0xAB, 0xCD → one `frame_err` pulse, followed by `word_valid` with `word_out`=16'hABCD (0x55 is not used as the high byte).
- **Reset between bytes:** send 0x99, assert `rst` for 3 cycles mid-gap, then send 0x01, 0x02 → `word_out`=16'h0102. All outputs are 0 during reset.
- **Back-to-back words:** send 0xDE, 0xAD, 0xBE, 0xEF with zero idle gap → two `word_valid` pulses, 16'hDEAD then 16'hBEEF, with `word_out` holding 16'hDEAD until the second pulse.
- **Parity (with `H_UART_RX_PARITY_EN`):** send 0x03 with parity bit 1 → `frame_err` pulse. Then send 0x03 (parity 0) and 0x07 (parity 1) → `word_out`=16'h0307.

Source files
------------

// File: rtl/h_uart_rx.sv
// Hack host-link UART receiver: 8N1 bytes are paired into 16-bit words, high byte first.
// Define H_UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module h_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
`ifdef H_UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd5;
`endif

  logic             sync_reg;
  logic             rxs_reg;
  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       high_reg;
  logic             phase_reg;
  logic             par_ok;

`ifdef H_UART_RX_PARITY_EN
  logic par_reg;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_ok = ((^shift_reg) == par_reg);
`else
  assign par_ok = 1'b1;
`endif

  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg    <= 1'b1;
      rxs_reg     <= 1'b1;
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      high_reg    <= 8'h00;
      phase_reg   <= 1'b0;
      word_out    <= 16'h0000;
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
`ifdef H_UART_RX_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      sync_reg   <= rx;
      rxs_reg    <= sync_reg;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (!rxs_reg) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
          end
        end

        S_START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg <= '0;
            if (!rxs_reg) begin
              state_reg   <= S_DATA;
              bit_idx_reg <= 3'd0;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg     <= '0;
            shift_reg   <= {rxs_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) begin
`ifdef H_UART_RX_PARITY_EN
              state_reg <= S_PARITY;
`else
              state_reg <= S_STOP;
`endif
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

`ifdef H_UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg   <= '0;
            par_reg   <= rxs_reg;
            state_reg <= S_STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg <= '0;
            if (rxs_reg && par_ok) begin
              state_reg <= S_IDLE;
              if (!phase_reg) begin
                high_reg  <= shift_reg;
                phase_reg <= 1'b1;
              end else begin
                word_out   <= {high_reg, shift_reg};
                word_valid <= 1'b1;
                phase_reg  <= 1'b0;
              end
            end else begin
              // A bad frame also drops any half-assembled word.
              frame_err <= 1'b1;
              phase_reg <= 1'b0;
              state_reg <= S_WAIT_IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (rxs_reg) begin
            state_reg <= S_IDLE;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
